// File: rtl/cis_ctrl_pkg.sv
// rtl/cis_ctrl_pkg.sv - shared types and widths for the CIS control path
package cis_ctrl_pkg;

    localparam int CLK_DIV_W       = 10;
    localparam int SKIP_W          = 10;
    localparam int GAP_W           = 16;
    localparam int DEF_TIME_W      = 24;
    localparam int DEF_FRAME_CNT_W = 16;

    typedef enum logic [1:0] {
        SEQ_IDLE    = 2'd0,
        SEQ_EXPOSE  = 2'd1,
        SEQ_READOUT = 2'd2,
        SEQ_GAP     = 2'd3
    } seq_state_t;

    // Shortest exposure that still spans one full pattern-engine clock period pair.
    function automatic logic [11:0] min_exposure(input logic [CLK_DIV_W-1:0] div);
        return ({2'b00, div} + 12'd1) << 1;
    endfunction

endpackage

// File: rtl/cis_frame_sequencer_if.sv
// rtl/cis_frame_sequencer_if.sv - control/config/status bundle of the frame sequencer
interface cis_frame_sequencer_if #(
    parameter int FRAME_CNT_W = cis_ctrl_pkg::DEF_FRAME_CNT_W,
    parameter int TIME_W      = cis_ctrl_pkg::DEF_TIME_W
);
    import cis_ctrl_pkg::*;

    logic                   start;
    logic                   abort;
    logic [FRAME_CNT_W-1:0] num_frames;
    logic [TIME_W-1:0]      exposure_cycles;
    logic [TIME_W-1:0]      readout_cycles;
    logic [GAP_W-1:0]       gap_cycles;
    logic [CLK_DIV_W-1:0]   clk_div_cfg;
    logic [SKIP_W-1:0]      skip_samples_cfg;

    logic                   integration;
    logic [CLK_DIV_W-1:0]   clk_div;
    logic [SKIP_W-1:0]      skip_samples;
    logic                   busy;
    logic                   frame_start;
    logic                   frame_done;
    logic                   seq_done;
    logic                   cfg_err;
    logic [FRAME_CNT_W-1:0] frame_count;

    modport master (
        output start, abort, num_frames, exposure_cycles, readout_cycles,
               gap_cycles, clk_div_cfg, skip_samples_cfg,
        input  integration, clk_div, skip_samples, busy, frame_start,
               frame_done, seq_done, cfg_err, frame_count
    );

    modport slave (
        input  start, abort, num_frames, exposure_cycles, readout_cycles,
               gap_cycles, clk_div_cfg, skip_samples_cfg,
        output integration, clk_div, skip_samples, busy, frame_start,
               frame_done, seq_done, cfg_err, frame_count
    );

endinterface

// File: rtl/cis_cycle_timer.sv
// rtl/cis_cycle_timer.sv - loadable down-counter that holds at zero
module cis_cycle_timer #(
    parameter int TIME_W = 24
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [TIME_W-1:0] value,
    output logic              zero
);

    logic [TIME_W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - TIME_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/cis_frame_sequencer.sv
// rtl/cis_frame_sequencer.sv - exposure/readout/gap frame scheduler for the CIS pattern engine
module cis_frame_sequencer
    import cis_ctrl_pkg::*;
#(
    parameter int FRAME_CNT_W = DEF_FRAME_CNT_W,
    parameter int TIME_W      = DEF_TIME_W
) (
    input  logic                  clk,
    input  logic                  reset_n,
    cis_frame_sequencer_if.slave  bus
);

    seq_state_t             state, state_d;
    logic                   abort_pend, abort_pend_d;
    logic                   tmr_load, tmr_zero;
    logic [TIME_W-1:0]      tmr_value;
    logic                   latch_cfg, clr_count, inc_count;
    logic                   frame_start_d, frame_done_d, seq_done_d, cfg_err_d;
    logic                   cfg_ok, last_frame, stop_req;

    logic                   integration_q, busy_q;
    logic                   frame_start_q, frame_done_q, seq_done_q, cfg_err_q;
    logic [CLK_DIV_W-1:0]   clk_div_q;
    logic [SKIP_W-1:0]      skip_q;
    logic [FRAME_CNT_W-1:0] frame_count_q;

    assign cfg_ok = (bus.exposure_cycles != '0) && (bus.readout_cycles != '0) &&
                    (bus.exposure_cycles >= TIME_W'(min_exposure(bus.clk_div_cfg)));

    assign last_frame = (bus.num_frames != '0) &&
                        ((frame_count_q + FRAME_CNT_W'(1)) == bus.num_frames);

    // An abort arriving on the final readout cycle is honoured as if it were pending.
    assign stop_req = abort_pend || bus.abort || last_frame;

    cis_cycle_timer #(.TIME_W(TIME_W)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (tmr_load),
        .value   (tmr_value),
        .zero    (tmr_zero)
    );

    always_comb begin
        state_d       = state;
        abort_pend_d  = abort_pend || bus.abort;
        tmr_load      = 1'b0;
        tmr_value     = '0;
        latch_cfg     = 1'b0;
        clr_count     = 1'b0;
        inc_count     = 1'b0;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        seq_done_d    = 1'b0;
        cfg_err_d     = 1'b0;
        case (state)
            SEQ_IDLE: begin
                abort_pend_d = 1'b0;
                if (bus.start && !bus.abort) begin
                    if (cfg_ok) begin
                        state_d       = SEQ_EXPOSE;
                        tmr_load      = 1'b1;
                        tmr_value     = bus.exposure_cycles - TIME_W'(1);
                        latch_cfg     = 1'b1;
                        clr_count     = 1'b1;
                        frame_start_d = 1'b1;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            SEQ_EXPOSE: begin
                if (bus.abort || tmr_zero) begin
                    state_d   = SEQ_READOUT;
                    tmr_load  = 1'b1;
                    tmr_value = bus.readout_cycles - TIME_W'(1);
                end
            end
            SEQ_READOUT: begin
                if (tmr_zero) begin
                    frame_done_d = 1'b1;
                    inc_count    = 1'b1;
                    if (stop_req) begin
                        state_d    = SEQ_IDLE;
                        seq_done_d = 1'b1;
                    end else if (bus.gap_cycles != '0) begin
                        state_d   = SEQ_GAP;
                        tmr_load  = 1'b1;
                        tmr_value = TIME_W'(bus.gap_cycles) - TIME_W'(1);
                    end else begin
                        state_d       = SEQ_EXPOSE;
                        tmr_load      = 1'b1;
                        tmr_value     = bus.exposure_cycles - TIME_W'(1);
                        latch_cfg     = 1'b1;
                        frame_start_d = 1'b1;
                    end
                end
            end
            SEQ_GAP: begin
                if (bus.abort) begin
                    state_d    = SEQ_IDLE;
                    seq_done_d = 1'b1;
                end else if (tmr_zero) begin
                    state_d       = SEQ_EXPOSE;
                    tmr_load      = 1'b1;
                    tmr_value     = bus.exposure_cycles - TIME_W'(1);
                    latch_cfg     = 1'b1;
                    frame_start_d = 1'b1;
                end
            end
            default: state_d = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= SEQ_IDLE;
            abort_pend    <= 1'b0;
            integration_q <= 1'b0;
            busy_q        <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            seq_done_q    <= 1'b0;
            cfg_err_q     <= 1'b0;
            clk_div_q     <= '0;
            skip_q        <= '0;
            frame_count_q <= '0;
        end else begin
            state         <= state_d;
            abort_pend    <= abort_pend_d;
            integration_q <= (state_d == SEQ_EXPOSE);
            busy_q        <= (state_d != SEQ_IDLE);
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            seq_done_q    <= seq_done_d;
            cfg_err_q     <= cfg_err_d;
            if (latch_cfg) begin
                clk_div_q <= bus.clk_div_cfg;
                skip_q    <= bus.skip_samples_cfg;
            end
            if (clr_count) begin
                frame_count_q <= '0;
            end else if (inc_count) begin
                frame_count_q <= frame_count_q + FRAME_CNT_W'(1);
            end
        end
    end

    assign bus.integration  = integration_q;
    assign bus.busy         = busy_q;
    assign bus.frame_start  = frame_start_q;
    assign bus.frame_done   = frame_done_q;
    assign bus.seq_done     = seq_done_q;
    assign bus.cfg_err      = cfg_err_q;
    assign bus.clk_div      = clk_div_q;
    assign bus.skip_samples = skip_q;
    assign bus.frame_count  = frame_count_q;

endmodule
